// File: rtl/ps2_rx_ctrl.sv
// PS/2 device-to-host receive controller.
// Synchronises and deglitches the PS/2 pins, detects falling clock edges and
// walks the 11-bit frame (start, D0..D7, odd parity, stop), delivering one
// byte per good frame plus one-cycle error pulses.
module ps2_rx_ctrl #(
  parameter int SYNC_STAGES    = 2,
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_W      = 17,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       parity_err,
  output logic       frame_err,
  output logic       timeout_err,
  output logic       busy
);

  localparam int FCNT_W = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  logic [SYNC_STAGES-1:0] clk_sync_reg;
  logic [SYNC_STAGES-1:0] data_sync_reg;
  logic                   clk_s;
  logic                   data_s;

  logic                   clk_f_reg;
  logic [FCNT_W-1:0]      filt_cnt_reg;
  logic                   differ;
  logic                   filt_load;
  logic                   fall_evt;

  state_t                 state_reg, state_next;
  logic [7:0]             shift_reg, shift_next;
  logic [3:0]             bit_cnt_reg, bit_cnt_next;
  logic                   parity_reg, parity_next;
  logic [TIMEOUT_W-1:0]   timer_reg, timer_next;
  logic [7:0]             rx_data_reg, rx_data_next;
  logic                   valid_reg, valid_next;
  logic                   perr_reg, perr_next;
  logic                   ferr_reg, ferr_next;
  logic                   terr_reg, terr_next;

  // Metastability chains; idle level of both PS/2 lines is high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_sync_reg  <= '1;
      data_sync_reg <= '1;
    end else begin
      clk_sync_reg  <= {clk_sync_reg[SYNC_STAGES-2:0], ps2_clk};
      data_sync_reg <= {data_sync_reg[SYNC_STAGES-2:0], ps2_data};
    end
  end

  assign clk_s  = clk_sync_reg[SYNC_STAGES-1];
  assign data_s = data_sync_reg[SYNC_STAGES-1];

  // The filtered clock follows the synchronised clock only once it has
  // disagreed for FILTER_LEN samples in a row; any agreement restarts the run.
  assign differ    = (clk_s != clk_f_reg);
  assign filt_load = differ && (filt_cnt_reg == FCNT_W'(FILTER_LEN - 1));
  assign fall_evt  = filt_load && clk_f_reg;

  // Filtered clock level and run-length counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_f_reg    <= 1'b1;
      filt_cnt_reg <= '0;
    end else if (filt_load) begin
      clk_f_reg    <= clk_s;
      filt_cnt_reg <= '0;
    end else if (differ) begin
      filt_cnt_reg <= filt_cnt_reg + FCNT_W'(1);
    end else begin
      filt_cnt_reg <= '0;
    end
  end

  // Frame state, datapath and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= IDLE;
      shift_reg   <= '0;
      bit_cnt_reg <= '0;
      parity_reg  <= 1'b0;
      timer_reg   <= '0;
      rx_data_reg <= '0;
      valid_reg   <= 1'b0;
      perr_reg    <= 1'b0;
      ferr_reg    <= 1'b0;
      terr_reg    <= 1'b0;
    end else begin
      state_reg   <= state_next;
      shift_reg   <= shift_next;
      bit_cnt_reg <= bit_cnt_next;
      parity_reg  <= parity_next;
      timer_reg   <= timer_next;
      rx_data_reg <= rx_data_next;
      valid_reg   <= valid_next;
      perr_reg    <= perr_next;
      ferr_reg    <= ferr_next;
      terr_reg    <= terr_next;
    end
  end

  // Next-state logic: advances on filtered falling edges, aborts on inactivity.
  always_comb begin
    state_next   = state_reg;
    shift_next   = shift_reg;
    bit_cnt_next = bit_cnt_reg;
    parity_next  = parity_reg;
    timer_next   = timer_reg;
    rx_data_next = rx_data_reg;
    valid_next   = 1'b0;
    perr_next    = 1'b0;
    ferr_next    = 1'b0;
    terr_next    = 1'b0;

    if (!en) begin
      // Disabled: drop any frame in progress without reporting it.
      state_next = IDLE;
      timer_next = '0;
    end else begin
      case (state_reg)
        IDLE: begin
          timer_next = '0;
          if (fall_evt && !data_s) begin
            state_next   = DATA;
            shift_next   = '0;
            bit_cnt_next = '0;
          end
        end
        default: begin
          if (fall_evt) begin
            // An edge always beats a coincident timeout.
            timer_next = '0;
            case (state_reg)
              DATA: begin
                shift_next   = {data_s, shift_reg[7:1]};
                bit_cnt_next = bit_cnt_reg + 4'd1;
                if (bit_cnt_reg == 4'd7) state_next = PARITY;
              end
              PARITY: begin
                parity_next = data_s;
                state_next  = STOP;
              end
              STOP: begin
                state_next = IDLE;
                if (data_s && ((^shift_reg) ^ parity_reg)) begin
                  rx_data_next = shift_reg;
                  valid_next   = 1'b1;
                end else begin
                  perr_next = !((^shift_reg) ^ parity_reg);
                  ferr_next = !data_s;
                end
              end
              default: state_next = IDLE;
            endcase
          end else if (timer_reg == TIMEOUT_W'(TIMEOUT_CYCLES - 1)) begin
            state_next = IDLE;
            timer_next = '0;
            terr_next  = 1'b1;
          end else begin
            timer_next = timer_reg + TIMEOUT_W'(1);
          end
        end
      endcase
    end
  end

  assign rx_data     = rx_data_reg;
  assign rx_valid    = valid_reg;
  assign parity_err  = perr_reg;
  assign frame_err   = ferr_reg;
  assign timeout_err = terr_reg;
  assign busy        = (state_reg != IDLE);

endmodule
